pipe_hazard_sb: RTL
===================

Name: pipe_hazard_sb

Overview:
- Parametrised, scoreboarded hazard unit for the 5-stage pipeline (F/D/E/M/W).
- Keeps the existing per-source M/W forwarding, load-use stall and branch/PC-write flushes, generalised to NSRC source operands.
- Adds one non-pipelined multicycle unit (MUL/DIV class). The block tracks its busy destination register with a countdown scoreboard and stalls D on RAW, WAW and structural conflicts.
- Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- RA_W, 4, register address width.
- NSRC, 2, source operands per instruction (1..4).
- MC_LAT, 4, multicycle unit latency in cycles, issue to writeback; must be >= 2.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- SrcD  in  NSRC*RA_W  D-stage source register addresses; operand i is at [i*RA_W +: RA_W].
- SrcValidD  in  NSRC  per-source valid in D.
- DstD  in  RA_W  D-stage destination register.
- RegWriteD  in  1  D instruction writes DstD.
- McD  in  1  D instruction is a multicycle op.
- SrcE  in  NSRC*RA_W  E-stage source addresses.
- SrcValidE  in  NSRC  per-source valid in E.
- DstE, DstM, DstW  in  RA_W  destination registers in E/M/W.
- RegWriteE, RegWriteM, RegWriteW  in  1  stage write enables.
- MemtoRegE  in  1  E instruction is a load.
- McE  in  1  E instruction is a multicycle op.
- BranchTakenE  in  1  branch resolved taken in E.
- PCWrPendingF  in  1  PC-writing instruction in flight.
- PCSrcW  in  1  PC written in W.
- ForwardE  out  2*NSRC  per-source select: 00 register file, 01 W result, 10 M result; 11 is never driven.
- StallF, StallD, FlushD, FlushE  out  1  pipeline controls.
- McBusy  out  1  multicycle unit holds an in-flight op.
- McWbW  out  1  multicycle result written this cycle via the dedicated write port.
- McDst  out  RA_W  scoreboarded destination register.
- StallCount  out  CNT_W  saturating count of StallD cycles.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - McBusy=0, count=0, McDst=0, StallCount=0.
  - Combinational outputs follow inputs with McBusy=0.
- Forwarding, per source i, with MatchX meaning SrcE[i]==DstX and SrcValidE[i]=1:
  - MatchM & RegWriteM gives 10.
  - Otherwise MatchW & RegWriteW gives 01.
  - Otherwise 00.
  - M has priority over W.
- McIssue = McE & RegWriteE. An op in E is committed; BranchTakenE does not cancel it.
- Scoreboard:
  - On McIssue: count is loaded with MC_LAT, McDst is loaded with DstE, and McBusy is set to 1.
  - While busy, count decrements by 1 each cycle.
  - When count==1, McWbW=1. On the next edge count becomes 0 and McBusy becomes 0.
  - If issue and completion coincide, issue wins. This cannot happen given the stall rules; verification asserts it never occurs.
- Hazard terms (D is the consumer):
  - lduse: any valid SrcD[i]==DstE with MemtoRegE=1.
  - mc_issue_raw: any valid SrcD[i]==DstE with McIssue=1.
  - mc_raw: McBusy=1 and any valid SrcD[i]==McDst.
  - mc_waw: McBusy=1 and RegWriteD=1 and DstD==McDst.
  - mc_struct: McD=1 and ((McBusy & count>1) | McIssue).
  - hz: OR of the five terms above.
- Pipeline controls:
  - StallD = hz.
  - StallF = hz | PCWrPendingF.
  - FlushE = hz | BranchTakenE.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - A stall and a flush in the same cycle are both asserted. The pipeline registers give flush priority over stall.
- Dependent D instruction:
  - It stalls through the cycle where count==1.
  - It enters E the cycle after. The register file already holds the result, so the select is 00.
- StallCount:
  - Increments on each clock edge where StallD=1.
  - Saturates at all-ones.
  - Cleared only by reset.
- Reset mid-operation: the in-flight op is abandoned; McBusy=0 immediately and McWbW stays low.

Test Plan:
- Forwarding: DstM=DstW=3, both write enables set, SrcE[0]=3 -> ForwardE[1:0]=10. Drop RegWriteM -> 01. Drop RegWriteW -> 00. SrcValidE[0]=0 -> 00.
- Load-use: MemtoRegE=1, DstE=5, SrcD[1]=5 -> StallD=StallF=FlushE=1 for exactly 1 cycle; StallCount +1.
- Multicycle RAW, MC_LAT=4: McIssue with DstE=7, then D reads r7.
  - Required: McBusy=1 for 4 cycles.
  - StallD=1 from the issue cycle through the count==1 cycle, which is 5 cycles including mc_issue_raw.
  - McWbW=1 in that last cycle; D proceeds the next cycle with select 00.
- Structural/WAW:
  - Second McD while count>1 -> StallD=1.
  - Second McD at count==1 -> no stall from mc_struct.
  - RegWriteD with DstD=McDst while busy -> stall.
- Branch plus stall: BranchTakenE=1 together with lduse -> FlushD=1, FlushE=1, StallD=1. An McIssue in the same cycle still sets McBusy.
- Reset mid-op: reset_n low while count==2 -> McBusy=0, McWbW stays 0, StallCount=0. Saturation: force 2^CNT_W+3 stall cycles -> StallCount=all-ones.

Source files
------------

// File: rtl/pipe_hazard_sb.sv
// pipe_hazard_sb -- hazard unit for the 5-stage F/D/E/M/W pipeline.
//
// Purpose:
//   Per-source M/W forwarding into E, load-use stall, branch/PC-write flushes,
//   and a countdown scoreboard for one non-pipelined multicycle unit
//   (MUL/DIV class). D is stalled on RAW, WAW and structural conflicts against
//   that unit. A saturating counter tracks the number of D-stall cycles.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   SrcD/SrcValidD                D-stage source addresses (operand i at [i*RA_W +: RA_W]) + valids
//   DstD, RegWriteD, McD          D-stage destination, write enable, multicycle flag
//   SrcE/SrcValidE                E-stage source addresses + valids
//   DstE/M/W, RegWriteE/M/W       stage destinations and write enables
//   MemtoRegE, McE                E instruction is a load / multicycle op
//   BranchTakenE, PCWrPendingF,
//   PCSrcW                        control-flow inputs
//   ForwardE                      per-source select: 00 RF, 01 W, 10 M
//   StallF, StallD, FlushD,
//   FlushE                        pipeline controls
//   McBusy, McWbW, McDst          multicycle scoreboard state / writeback strobe
//   StallCount                    saturating count of StallD cycles
module pipe_hazard_sb #(
  parameter int RA_W   = 4,
  parameter int NSRC   = 2,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NSRC*RA_W-1:0]   SrcD,
  input  logic [NSRC-1:0]        SrcValidD,
  input  logic [RA_W-1:0]        DstD,
  input  logic                   RegWriteD,
  input  logic                   McD,
  input  logic [NSRC*RA_W-1:0]   SrcE,
  input  logic [NSRC-1:0]        SrcValidE,
  input  logic [RA_W-1:0]        DstE,
  input  logic [RA_W-1:0]        DstM,
  input  logic [RA_W-1:0]        DstW,
  input  logic                   RegWriteE,
  input  logic                   RegWriteM,
  input  logic                   RegWriteW,
  input  logic                   MemtoRegE,
  input  logic                   McE,
  input  logic                   BranchTakenE,
  input  logic                   PCWrPendingF,
  input  logic                   PCSrcW,
  output logic [2*NSRC-1:0]      ForwardE,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic                   McBusy,
  output logic                   McWbW,
  output logic [RA_W-1:0]        McDst,
  output logic [CNT_W-1:0]       StallCount
);

  localparam int            CW    = $clog2(MC_LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(MC_LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic              busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RA_W-1:0]   dst_q, dst_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;

  logic mc_issue;
  logic lduse, mc_issue_raw, mc_raw, mc_waw, mc_struct, hz;

  // An op reaching E is committed: a taken branch in the same cycle does not cancel it.
  assign mc_issue = McE & RegWriteE;

  // Forwarding into E; M is the younger result so it wins over W.
  always_comb begin
    ForwardE = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (SrcValidE[i] && RegWriteM && (SrcE[i*RA_W +: RA_W] == DstM))
        ForwardE[2*i +: 2] = 2'b10;
      else if (SrcValidE[i] && RegWriteW && (SrcE[i*RA_W +: RA_W] == DstW))
        ForwardE[2*i +: 2] = 2'b01;
    end
  end

  // Hazard detection with D as the consumer.
  always_comb begin
    lduse        = 1'b0;
    mc_issue_raw = 1'b0;
    mc_raw       = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (SrcValidD[i]) begin
        if (MemtoRegE && (SrcD[i*RA_W +: RA_W] == DstE))  lduse        = 1'b1;
        if (mc_issue && (SrcD[i*RA_W +: RA_W] == DstE))   mc_issue_raw = 1'b1;
        if (busy_q && (SrcD[i*RA_W +: RA_W] == dst_q))    mc_raw       = 1'b1;
      end
    end
    mc_waw    = busy_q & RegWriteD & (DstD == dst_q);
    // At count==1 the unit frees on the next edge, exactly when D would issue.
    mc_struct = McD & ((busy_q & (cnt_q > ONE_C)) | mc_issue);
    hz        = lduse | mc_issue_raw | mc_raw | mc_waw | mc_struct;
  end

  assign StallD = hz;
  assign StallF = hz | PCWrPendingF;
  assign FlushE = hz | BranchTakenE;
  assign FlushD = PCWrPendingF | PCSrcW | BranchTakenE;

  assign McBusy     = busy_q;
  assign McWbW      = busy_q & (cnt_q == ONE_C);
  assign McDst      = dst_q;
  assign StallCount = scnt_q;

  // Scoreboard and stall-counter next state; a new issue takes precedence over completion.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    dst_d  = dst_q;
    scnt_d = scnt_q;
    if (mc_issue) begin
      busy_d = 1'b1;
      cnt_d  = LAT_C;
      dst_d  = DstE;
    end else if (busy_q) begin
      cnt_d = cnt_q - ONE_C;
      if (cnt_q == ONE_C) busy_d = 1'b0;
    end
    if (hz && (scnt_q != {CNT_W{1'b1}})) scnt_d = scnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dst_q  <= '0;
      scnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dst_q  <= dst_d;
      scnt_q <= scnt_d;
    end
  end

endmodule
